timepulse_sequencer: RTL



---
 rtl/timepulse_sequencer_pkg.sv | 31 +++
 rtl/timepulse_sequencer_rise_detect.sv | 29 ++
 rtl/timepulse_sequencer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/timepulse_sequencer_pkg.sv
// Shared definitions for the AGC timepulse sequencer: state encodings,
// timepulse width/reset pattern and the one-hot rotate helper.
package timepulse_sequencer_pkg;

    localparam int T_W = 12;

    localparam logic [T_W-1:0] T_RESET = 12'h800;
    localparam logic [T_W-1:0] T_FIRST = 12'h001;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_STOPPED  = 2'd1,
        ST_STEP_ARM = 2'd2,
        ST_STEP_RUN = 2'd3
    } tp_state_e;

    // One timepulse step: T01 -> T02 ... T12 -> T01.
    function automatic logic [T_W-1:0] t_rotate(input logic [T_W-1:0] t_in);
        t_rotate = {t_in[T_W-2:0], t_in[T_W-1]};
    endfunction

    function automatic logic t_is_last(input logic [T_W-1:0] t_in);
        t_is_last = t_in[T_W-1];
    endfunction

    // Halted states present STOPPED to the outside world.
    function automatic logic state_is_halted(input tp_state_e st);
        state_is_halted = (st == ST_STOPPED) || (st == ST_STEP_ARM);
    endfunction

endpackage

// File: rtl/timepulse_sequencer_rise_detect.sv
// Rising-edge detector with previous sample preset high, so an input that is
// already high when reset releases does not register as an edge.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic prev_q;
    logic prev_d;

    // Next previous-sample value is simply the current input.
    always_comb begin
        prev_d = din;
    end

    // Previous-sample register, preset to 1 on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise = din & ~prev_q;

endmodule

// File: rtl/timepulse_sequencer.sv
// AGC timepulse generator: steps a one-hot T01..T12 on each PHS4 rise and
// applies monitor stop, single-step and GOJAM restart at MCT boundaries.
module timepulse_sequencer
    import timepulse_sequencer_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             CLOCK,
    input  logic             SIM_RST,
    input  logic             VCC,
    input  logic             GND,
    input  logic             PHS4,
    input  logic             GOJAM,
    input  logic             MSTP,
    input  logic             MSTEP,
    output logic [T_W-1:0]   T,
    output logic             MCT_END,
    output logic             STOPPED,
    output logic [CNT_W-1:0] MCTCNT
);

    logic unused_rails_s;
    assign unused_rails_s = VCC ^ GND;

    logic step_s;
    logic mstep_rise_s;

    rise_detect u_phs4_rise (
        .clk  (CLOCK),
        .rst  (SIM_RST),
        .din  (PHS4),
        .rise (step_s)
    );

    rise_detect u_mstep_rise (
        .clk  (CLOCK),
        .rst  (SIM_RST),
        .din  (MSTEP),
        .rise (mstep_rise_s)
    );

    tp_state_e        state_q,   state_d;
    logic [T_W-1:0]   t_q,       t_d;
    logic             mct_end_q, mct_end_d;
    logic             stopped_q, stopped_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;

    logic [T_W-1:0]   t_adv_s;
    logic             wrap_s;
    logic [CNT_W-1:0] cnt_inc_s;

    assign t_adv_s   = t_rotate(t_q);
    assign wrap_s    = t_is_last(t_q);
    assign cnt_inc_s = cnt_q + CNT_W'(1);

    // Next-state logic: GOJAM first, then per-state step handling.
    always_comb begin
        state_d   = state_q;
        t_d       = t_q;
        mct_end_d = 1'b0;
        cnt_d     = cnt_q;

        if (GOJAM) begin
            state_d = ST_RUN;
            t_d     = T_RESET;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (step_s && wrap_s && MSTP) begin
                        state_d = ST_STOPPED;
                    end else if (step_s) begin
                        t_d       = t_adv_s;
                        mct_end_d = wrap_s;
                        cnt_d     = wrap_s ? cnt_inc_s : cnt_q;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_STOPPED: begin
                    // A falling MSTP wins over a coincident MSTEP rise.
                    if (!MSTP && step_s) begin
                        state_d   = ST_RUN;
                        t_d       = t_adv_s;
                        mct_end_d = wrap_s;
                        cnt_d     = wrap_s ? cnt_inc_s : cnt_q;
                    end else if (MSTP && mstep_rise_s) begin
                        state_d = ST_STEP_ARM;
                    end else begin
                        state_d = ST_STOPPED;
                    end
                end
                ST_STEP_ARM: begin
                    if (step_s) begin
                        state_d   = ST_STEP_RUN;
                        t_d       = t_adv_s;
                        mct_end_d = wrap_s;
                        cnt_d     = wrap_s ? cnt_inc_s : cnt_q;
                    end else begin
                        state_d = ST_STEP_ARM;
                    end
                end
                ST_STEP_RUN: begin
                    if (step_s && wrap_s && MSTP) begin
                        state_d = ST_STOPPED;
                    end else if (step_s) begin
                        state_d   = wrap_s ? ST_RUN : ST_STEP_RUN;
                        t_d       = t_adv_s;
                        mct_end_d = wrap_s;
                        cnt_d     = wrap_s ? cnt_inc_s : cnt_q;
                    end else begin
                        state_d = ST_STEP_RUN;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    t_d     = T_RESET;
                end
            endcase
        end

        stopped_d = state_is_halted(state_d);
    end

    // Sequencer state and all registered outputs.
    always_ff @(posedge CLOCK or posedge SIM_RST) begin
        if (SIM_RST) begin
            state_q   <= ST_RUN;
            t_q       <= T_RESET;
            mct_end_q <= 1'b0;
            stopped_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            t_q       <= t_d;
            mct_end_q <= mct_end_d;
            stopped_q <= stopped_d;
            cnt_q     <= cnt_d;
        end
    end

    assign T       = t_q;
    assign MCT_END = mct_end_q;
    assign STOPPED = stopped_q;
    assign MCTCNT  = cnt_q;

endmodule
